// File: rtl/proc_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : proc_mem_responder_if
// Purpose : val/rdy request/response bundle between processor and memory.
// Rev     : 1.0  initial release
// ============================================================================
interface proc_mem_responder_if;
  logic        req_val;
  logic        req_rdy;
  logic [2:0]  req_type;
  logic [7:0]  req_opaque;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_data;
  logic        resp_val;
  logic        resp_rdy;
  logic [2:0]  resp_type;
  logic [7:0]  resp_opaque;
  logic [1:0]  resp_test;
  logic [1:0]  resp_len;
  logic [31:0] resp_data;

  modport master (
    output req_val, req_type, req_opaque, req_addr, req_len, req_data, resp_rdy,
    input  req_rdy, resp_val, resp_type, resp_opaque, resp_test, resp_len, resp_data
  );

  modport slave (
    input  req_val, req_type, req_opaque, req_addr, req_len, req_data, resp_rdy,
    output req_rdy, resp_val, resp_type, resp_opaque, resp_test, resp_len, resp_data
  );
endinterface
`default_nettype wire

// File: rtl/proc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : proc_mem_responder
// Purpose : Single-port word memory answering val/rdy requests in order after
//           a fixed lockstep pipeline latency.
// Rev     : 1.0  initial release
// ============================================================================
module proc_mem_responder #(
  parameter int P_NUM_WORDS = 256,
  parameter int P_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  proc_mem_responder_if.slave   bus
);

  localparam int c_AW   = $clog2(P_NUM_WORDS);
  localparam int c_LAST = P_LATENCY - 1;

  typedef struct packed {
    logic        val;
    logic [2:0]  typ;
    logic [7:0]  opq;
    logic [1:0]  len;
    logic [31:0] data;
  } stage_t;

  function automatic logic [31:0] f_bytes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  logic [31:0]     r_mem [P_NUM_WORDS];
  stage_t          r_stage [P_LATENCY];

  logic [c_AW-1:0] w_idx;
  logic [1:0]      w_off;
  logic [3:0]      w_nmask;
  logic [3:0]      w_wmask;
  logic [31:0]     w_wbm;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rword;
  logic [31:0]     w_rdata;
  logic            w_is_wr;
  logic            w_adv;
  logic            w_acc;
  stage_t          w_next;
  logic            w_unused;

  assign w_idx    = bus.req_addr[c_AW+1:2];
  assign w_off    = bus.req_addr[1:0];
  assign w_unused = ^bus.req_addr[31:c_AW+2];
  assign w_is_wr  = (bus.req_type == 3'd1);

  always_comb begin
    case (bus.req_len)
      2'd1:    w_nmask = 4'h1;
      2'd2:    w_nmask = 4'h3;
      2'd3:    w_nmask = 4'h7;
      default: w_nmask = 4'hF;
    endcase
  end

  // Lanes shifted past byte 3 fall off the 4-bit mask: boundary truncation.
  assign w_wmask = w_nmask << w_off;
  assign w_wbm   = f_bytes(w_wmask);
  assign w_wdata = bus.req_data << {w_off, 3'b000};
  assign w_rword = r_mem[w_idx];
  assign w_rdata = (w_rword >> {w_off, 3'b000}) & f_bytes(w_nmask);

  assign w_adv       = !r_stage[c_LAST].val || bus.resp_rdy;
  assign bus.req_rdy = w_adv;
  assign w_acc       = bus.req_val && w_adv;

  assign w_next.val  = w_acc;
  assign w_next.typ  = bus.req_type;
  assign w_next.opq  = bus.req_opaque;
  assign w_next.len  = bus.req_len;
  assign w_next.data = w_is_wr ? 32'h0 : w_rdata;

  // Array is deliberately outside reset so contents survive a pipeline flush.
  always_ff @(posedge clk) begin
    if (w_acc && w_is_wr) begin
      r_mem[w_idx] <= (w_rword & ~w_wbm) | (w_wdata & w_wbm);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < P_LATENCY; s++) begin
        r_stage[s] <= '0;
      end
    end else if (w_adv) begin
      r_stage[0] <= w_next;
      for (int s = 1; s < P_LATENCY; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign bus.resp_val    = r_stage[c_LAST].val;
  assign bus.resp_type   = r_stage[c_LAST].typ;
  assign bus.resp_opaque = r_stage[c_LAST].opq;
  assign bus.resp_len    = r_stage[c_LAST].len;
  assign bus.resp_data   = r_stage[c_LAST].data;
  assign bus.resp_test   = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_proc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_proc_mem_responder
// Purpose : Directed plus random checks of proc_mem_responder at latency 2
//           and latency 1 against a byte-level memory model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_proc_mem_responder;

  localparam int c_LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  proc_mem_responder_if b0 ();
  proc_mem_responder_if b1 ();

  proc_mem_responder #(.P_NUM_WORDS(256), .P_LATENCY(c_LAT)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  proc_mem_responder #(.P_NUM_WORDS(256), .P_LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  typedef struct {
    logic [2:0]  typ;
    logic [7:0]  opq;
    logic [1:0]  len;
    logic [31:0] data;
    int          acc;
  } rsp_t;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  rsp_t        exp_q[$];
  rsp_t        mon_e;
  logic [7:0]  mb0 [1024];
  logic [7:0]  mb1 [1024];
  logic        chk_lat    = 1'b0;
  logic        saw_block  = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_opq   = 8'h0;
  logic [31:0] prev_data  = 32'h0;
  logic [31:0] last_rd    = 32'h0;
  logic [31:0] exp1 [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-granular reference memory; sel picks which DUT's image is used.
  function automatic logic [31:0] model(input bit sel, input logic [2:0] typ,
                                        input logic [31:0] addr, input logic [1:0] len,
                                        input logic [31:0] data);
    int          w = int'((addr >> 2) % 256);
    int          o = int'(addr % 4);
    int          n = (len == 2'd0) ? 4 : int'(len);
    logic [31:0] r = 32'h0;
    if (typ == 3'd1) begin
      for (int i = 0; i < n; i++) begin
        if (o + i < 4) begin
          if (sel) mb1[w*4+o+i] = data[8*i +: 8];
          else     mb0[w*4+o+i] = data[8*i +: 8];
        end
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        if (o + k < 4) r[8*k +: 8] = sel ? mb1[w*4+o+k] : mb0[w*4+o+k];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("req_rdy_rule", 32'(b0.req_rdy), 32'(!(b0.resp_val && !b0.resp_rdy)));
      if (b0.req_val && !b0.req_rdy) saw_block = 1'b1;
      if (prev_stall) begin
        chk("hold_val", 32'(b0.resp_val), 32'd1);
        chk("hold_opq", 32'(b0.resp_opaque), 32'(prev_opq));
        chk("hold_data", b0.resp_data, prev_data);
      end
      if (b0.resp_val) begin
        if (exp_q.size() == 0) begin
          chk("spurious_resp", 32'(b0.resp_val), 32'd0);
        end else begin
          mon_e = exp_q[0];
          chk("resp_type", 32'(b0.resp_type), 32'(mon_e.typ));
          chk("resp_opq", 32'(b0.resp_opaque), 32'(mon_e.opq));
          chk("resp_len", 32'(b0.resp_len), 32'(mon_e.len));
          chk("resp_data", b0.resp_data, mon_e.data);
          chk("resp_test", 32'(b0.resp_test), 32'd0);
          if (b0.resp_rdy) begin
            if (chk_lat) chk("latency", 32'(cyc - mon_e.acc), 32'(c_LAT));
            last_rd = b0.resp_data;
            void'(exp_q.pop_front());
          end
        end
      end
      if (b0.req_val && b0.req_rdy) begin
        mon_e.typ  = b0.req_type;
        mon_e.opq  = b0.req_opaque;
        mon_e.len  = b0.req_len;
        mon_e.data = model(1'b0, b0.req_type, b0.req_addr, b0.req_len, b0.req_data);
        mon_e.acc  = cyc;
        exp_q.push_back(mon_e);
      end
      prev_stall = b0.resp_val && !b0.resp_rdy;
      prev_opq   = b0.resp_opaque;
      prev_data  = b0.resp_data;
    end
  end

  task automatic send(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                      input logic [1:0] l, input logic [31:0] d);
    bit acc = 1'b0;
    b0.req_val    = 1'b1;
    b0.req_type   = t;
    b0.req_opaque = o;
    b0.req_addr   = a;
    b0.req_len    = l;
    b0.req_data   = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = b0.req_rdy;
      @(posedge clk);
      #1;
    end
    b0.req_val = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    b0.req_val = 1'b0; b0.req_type = 3'd0; b0.req_opaque = 8'h0; b0.req_addr = 32'h0;
    b0.req_len = 2'd0; b0.req_data = 32'h0; b0.resp_rdy = 1'b1;
    b1.req_val = 1'b0; b1.req_type = 3'd0; b1.req_opaque = 8'h0; b1.req_addr = 32'h0;
    b1.req_len = 2'd0; b1.req_data = 32'h0; b1.resp_rdy = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_val", 32'(b0.resp_val), 32'd0);
    chk("rst_resp_type", 32'(b0.resp_type), 32'd0);
    chk("rst_resp_opq", 32'(b0.resp_opaque), 32'd0);
    chk("rst_resp_len", 32'(b0.resp_len), 32'd0);
    chk("rst_resp_data", b0.resp_data, 32'd0);
    chk("rst_l1_resp_val", 32'(b1.resp_val), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back write then read with latency checking enabled.
    chk_lat = 1'b1;
    send(3'd1, 8'h11, 32'h200, 2'd0, 32'hDEADBEEF);
    send(3'd0, 8'h12, 32'h200, 2'd0, 32'h0);
    drain();
    chk("rd_after_wr", last_rd, 32'hDEADBEEF);

    // Sub-word write and truncated reads.
    send(3'd1, 8'h21, 32'h100, 2'd0, 32'h11223344);
    send(3'd1, 8'h22, 32'h101, 2'd1, 32'h000000AA);
    send(3'd0, 8'h23, 32'h100, 2'd0, 32'h0);
    drain();
    chk("byte_merge", last_rd, 32'h1122AA44);
    send(3'd0, 8'h24, 32'h102, 2'd2, 32'h0);
    drain();
    chk("half_read", last_rd, 32'h00001122);
    send(3'd0, 8'h25, 32'h103, 2'd2, 32'h0);
    drain();
    chk("trunc_read", last_rd, 32'h00000011);

    // Address aliasing above the array size.
    send(3'd1, 8'h31, 32'h0000_0004, 2'd0, 32'h5);
    send(3'd2, 8'h32, 32'h0000_0404, 2'd0, 32'h0);
    drain();
    chk("alias_read", last_rd, 32'h5);

    // Backpressure: four tagged reads with responses blocked for five cycles.
    chk_lat      = 1'b0;
    saw_block    = 1'b0;
    b0.resp_rdy  = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 b0.resp_rdy = 1'b1;
      end
    join_none
    for (int t = 1; t <= 4; t++) send(3'd0, 8'(t), 32'h100, 2'd0, 32'h0);
    drain();
    chk("stall_blocked", 32'(saw_block), 32'd1);
    chk("stall_last_tag_data", last_rd, 32'h1122AA44);

    // Reset with two reads in flight; the earlier write must survive.
    chk_lat = 1'b1;
    send(3'd1, 8'h41, 32'h300, 2'd0, 32'hCAFEF00D);
    drain();
    send(3'd0, 8'h42, 32'h300, 2'd0, 32'h0);
    send(3'd0, 8'h43, 32'h300, 2'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_val", 32'(b0.resp_val), 32'd0);
    chk("async_rst_data", b0.resp_data, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_resp_after_rst", 32'(b0.resp_val), 32'd0);
    end
    @(posedge clk);
    #1;
    send(3'd0, 8'h44, 32'h300, 2'd0, 32'h0);
    drain();
    chk("mem_kept_over_rst", last_rd, 32'hCAFEF00D);

    // Random traffic over a pre-written window with random backpressure.
    for (int w = 0; w < 16; w++) send(3'd1, 8'(w), 32'h100 + 32'(w * 4), 2'd0, $urandom);
    drain();
    chk_lat = 1'b0;
    for (int i = 0; i < 200; i++) begin
      b0.req_val    = ($urandom_range(0, 3) != 0);
      b0.req_type   = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7));
      b0.req_opaque = 8'($urandom);
      b0.req_addr   = ($urandom & 32'hFFFF_FC00) | (32'h100 + 32'($urandom_range(0, 15) * 4))
                      | 32'($urandom_range(0, 3));
      b0.req_len    = 2'($urandom_range(0, 3));
      b0.req_data   = $urandom;
      b0.resp_rdy   = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    b0.req_val  = 1'b0;
    b0.resp_rdy = 1'b1;
    drain();

    // Latency 1: alternating write/read, one response every cycle.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        b1.req_val    = 1'b1;
        b1.req_type   = (i % 2 == 0) ? 3'd1 : 3'd0;
        b1.req_opaque = 8'(i);
        b1.req_addr   = 32'h40 + 32'((i / 2) * 4);
        b1.req_len    = 2'd0;
        b1.req_data   = $urandom;
        exp1[i]       = model(1'b1, b1.req_type, b1.req_addr, b1.req_len, b1.req_data);
      end else begin
        b1.req_val = 1'b0;
      end
      @(negedge clk);
      if (i < 8) chk("l1_req_rdy", 32'(b1.req_rdy), 32'd1);
      if (i > 0) begin
        chk("l1_resp_val", 32'(b1.resp_val), 32'd1);
        chk("l1_resp_opq", 32'(b1.resp_opaque), 32'(i - 1));
        chk("l1_resp_data", b1.resp_data, exp1[i-1]);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("l1_idle", 32'(b1.resp_val), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
- Single-port memory responder for the processor's imem/dmem request/response streams; the memory side of the val/rdy protocol the processor datapath drives.
- Accepts one request per cycle and performs the read/write against an internal word array.
- Returns responses in order after a fixed pipeline latency, stalling cleanly under response backpressure.
- Used as the behavioural memory in processor test harnesses and as the base for the later cache/memory-system blocks.

Parameters:
- p_num_words, 256, number of 32-bit words in the array; must be a power of two.
- p_latency, 2, cycles from request accept to response valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_type  in  3  0 = read, 1 = write; other codes are treated as read.
- req_opaque  in  8  tag echoed in the response.
- req_addr  in  32  byte address.
- req_len  in  2  byte count; 0 means 4 bytes.
- req_data  in  32  write data, right-aligned.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_type  out  3  echoed request type.
- resp_opaque  out  8  echoed tag.
- resp_test  out  2  always 0.
- resp_len  out  2  echoed len.
- resp_data  out  32  read data; 0 for writes.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All pipeline valid bits clear, so resp_val = 0.
  - resp_type, resp_opaque, resp_len and resp_data = 0.
  - The array is NOT cleared. Pipeline state takes effect immediately, independent of clk.
- Reset mid-operation: all in-flight requests are discarded and no response is ever produced for them. Writes already performed remain in the array.
- Accept:
  - A request is accepted on a rising edge where req_val && req_rdy.
  - req_rdy = !stage[p_latency-1].val || resp_rdy (combinational). It may depend on resp_rdy but never on req_val.
- Memory access happens at the accept edge:
  - Word index = req_addr[log2(p_num_words)+1:2]; upper address bits alias (wrap).
  - Byte offset o = req_addr[1:0]; n = req_len, or 4 when req_len = 0.
- Write: bytes o..min(o+n,4)-1 of the word receive req_data bytes 0..; bytes that would cross the word boundary are dropped.
- Read:
  - resp_data byte k = word byte o+k for k < n and o+k < 4; all other bytes are 0 (zero-extended, truncated at the word boundary).
  - Read data is captured at accept, so a read sees every earlier-accepted write, including a write accepted in the immediately preceding cycle.
- Pipeline:
  - p_latency stages, each holding a val bit plus the response fields. Stage 0 loads on accept.
  - The whole pipeline advances when advance = !stage[last].val || resp_rdy; otherwise every stage holds.
  - resp_* outputs come straight from stage[last].
  - Latency: a request accepted at edge t gives resp_val high in the cycle after edge t+p_latency-1, provided there is no backpressure.
  - Throughput is one request per cycle with resp_rdy held high.
- Backpressure:
  - While resp_val && !resp_rdy, resp_* are held stable and req_rdy = 0.
  - Bubbles are not compressed; this is simple lockstep stalling.
- Simultaneous accept and response handshake in the same cycle is legal and is the steady state.
- Ordering: responses are strictly in acceptance order; the opaque tag is echoed unchanged.
- p_latency = 1: a single stage, so the response is valid in the cycle after accept.

Test Plan:
- Write 0xDEADBEEF at addr 0x200 (len 0), then read 0x200 (len 0) back-to-back with resp_rdy = 1 -> write response data 0 with opaque echoed; read response data 0xDEADBEEF in the cycle after the write response; both arrive p_latency cycles after their accepts.
- Word at 0x100 = 0x11223344; write 0xAA at 0x101, len 1 -> read 0x100 returns 0x1122AA44. Read 0x102, len 2 -> 0x00001122. Read 0x103, len 2 -> 0x00000011 (truncated).
- Issue 4 reads with opaque tags 1..4 while resp_rdy = 0 for 5 cycles -> req_rdy drops once the last stage is full, the head response is held stable, and after release the tags return in order 1, 2, 3, 4 with no loss or duplication.
- Aliasing with p_num_words = 256: write 0x5 to 0x0000_0004, read 0x0000_0404 -> data 0x5.
- Assert reset low for 1 cycle with 2 reads in flight -> resp_val = 0 immediately and those reads produce no responses; a write accepted before the reset is still readable after it.
- p_latency = 1, 8 alternating write/read requests with resp_rdy = 1 -> req_rdy stays 1 throughout, one response per cycle, and each read returns the immediately preceding write's data.
